// File: rtl/train_pkg.sv
// Shared types and field layout for the training-sample sequencer.
// Sample word layout: {x1[7:0], x2[7:0], label, pad}.
package train_pkg;

    localparam int WORD_WIDTH = 18;
    localparam int FEAT_WIDTH = 8;
    localparam int X1_MSB     = 17;
    localparam int X2_MSB     = 9;
    localparam int LABEL_BIT  = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPTURE,
        ST_ISSUE_A,
        ST_ISSUE_B,
        ST_DRAIN,
        ST_EPOCH_END,
        ST_DONE
    } state_t;

    function automatic logic signed [FEAT_WIDTH-1:0] get_x1(input logic [WORD_WIDTH-1:0] w);
        return w[X1_MSB -: FEAT_WIDTH];
    endfunction

    function automatic logic signed [FEAT_WIDTH-1:0] get_x2(input logic [WORD_WIDTH-1:0] w);
        return w[X2_MSB -: FEAT_WIDTH];
    endfunction

    function automatic logic get_label(input logic [WORD_WIDTH-1:0] w);
        return w[LABEL_BIT];
    endfunction

endpackage

// File: rtl/sample_field_unpack.sv
// Combinational split of one sample word into its Q4.4 features and class label.
module sample_field_unpack
    import train_pkg::*;
(
    input  logic        [WORD_WIDTH-1:0] word,
    output logic signed [FEAT_WIDTH-1:0] x1,
    output logic signed [FEAT_WIDTH-1:0] x2,
    output logic                         label
);

    assign x1    = get_x1(word);
    assign x2    = get_x2(word);
    assign label = get_label(word);

endmodule

// File: rtl/train_sample_sequencer.sv
// Epoch controller: walks the sample memory pairing class halves, streams samples
// over valid/ready and repeats epochs until an error-free pass or the epoch limit.
module train_sample_sequencer #(
    parameter int SAMPLE_WIDTH = 18,
    parameter int ADDR_WIDTH   = 6,
    parameter int FEAT_WIDTH   = 8,
    parameter int MAX_EPOCHS   = 16,
    parameter int EPOCH_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic        [ADDR_WIDTH-1:0]  mem_addr_a,
    output logic        [ADDR_WIDTH-1:0]  mem_addr_b,
    input  logic        [SAMPLE_WIDTH-1:0] mem_data_a,
    input  logic        [SAMPLE_WIDTH-1:0] mem_data_b,
    output logic                          s_valid,
    input  logic                          s_ready,
    output logic signed [FEAT_WIDTH-1:0]  s_x1,
    output logic signed [FEAT_WIDTH-1:0]  s_x2,
    output logic                          s_label,
    output logic        [ADDR_WIDTH-1:0]  s_index,
    input  logic                          err_valid,
    input  logic                          err,
    output logic                          busy,
    output logic                          done,
    output logic                          converged,
    output logic        [EPOCH_WIDTH-1:0] epoch_cnt,
    output logic        [ADDR_WIDTH:0]    last_err_cnt,
    output logic                          protocol_err
);
    import train_pkg::*;

    localparam int NUM  = 2**ADDR_WIDTH;
    localparam int HALF = NUM / 2;
    localparam logic [ADDR_WIDTH-1:0]  HALF_ADDR = ADDR_WIDTH'(HALF);
    localparam logic [ADDR_WIDTH-1:0]  LAST_K    = ADDR_WIDTH'(HALF - 1);
    localparam logic [ADDR_WIDTH:0]    NUM_CNT   = (ADDR_WIDTH + 1)'(NUM);
    localparam logic [EPOCH_WIDTH-1:0] EPOCH_SAT = '1;

    state_t state, state_nxt;

    logic        [ADDR_WIDTH-1:0]   k;
    logic        [SAMPLE_WIDTH-1:0] samp_a_p1;
    logic        [SAMPLE_WIDTH-1:0] samp_b_p1;
    logic        [ADDR_WIDTH:0]     resp_cnt;
    logic        [ADDR_WIDTH:0]     err_cnt;
    logic        [ADDR_WIDTH:0]     resp_cnt_nxt;
    logic signed [FEAT_WIDTH-1:0]   a_x1, a_x2, b_x1, b_x2;
    logic                           a_label, b_label;
    logic                           resp_bad, resp_ok, epoch_last;

    assign mem_addr_a = k;
    assign mem_addr_b = HALF_ADDR + k;

    // A response is dropped (and flagged) when nothing is running or the epoch is already full.
    assign resp_bad     = err_valid && (!busy || resp_cnt == NUM_CNT);
    assign resp_ok      = err_valid && !resp_bad;
    assign resp_cnt_nxt = resp_cnt + {{ADDR_WIDTH{1'b0}}, resp_ok};
    assign epoch_last   = (32'(epoch_cnt) + 32'd1) >= 32'(MAX_EPOCHS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        s_valid   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        s_index   = k;
        s_x1      = a_x1;
        s_x2      = a_x2;
        s_label   = a_label;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = ST_FETCH;
            end
            ST_FETCH:   state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = ST_ISSUE_A;
            ST_ISSUE_A: begin
                s_valid = 1'b1;
                if (s_ready) state_nxt = ST_ISSUE_B;
            end
            ST_ISSUE_B: begin
                s_valid = 1'b1;
                s_index = mem_addr_b;
                s_x1    = b_x1;
                s_x2    = b_x2;
                s_label = b_label;
                if (s_ready) state_nxt = (k == LAST_K) ? ST_DRAIN : ST_FETCH;
            end
            ST_DRAIN: begin
                if (resp_cnt_nxt == NUM_CNT) state_nxt = ST_EPOCH_END;
            end
            ST_EPOCH_END: begin
                state_nxt = (err_cnt == '0 || epoch_last) ? ST_DONE : ST_FETCH;
            end
            ST_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stage p1: memory read data captured one cycle after the address was presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_a_p1 <= '0;
            samp_b_p1 <= '0;
        end else if (state == ST_CAPTURE) begin
            samp_a_p1 <= mem_data_a;
            samp_b_p1 <= mem_data_b;
        end
    end

    sample_field_unpack u_unpack_a (
        .word  (samp_a_p1),
        .x1    (a_x1),
        .x2    (a_x2),
        .label (a_label)
    );

    sample_field_unpack u_unpack_b (
        .word  (samp_b_p1),
        .x1    (b_x1),
        .x2    (b_x2),
        .label (b_label)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k            <= '0;
            resp_cnt     <= '0;
            err_cnt      <= '0;
            epoch_cnt    <= '0;
            last_err_cnt <= '0;
            converged    <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            if (resp_bad) protocol_err <= 1'b1;
            if (resp_ok) begin
                resp_cnt <= resp_cnt_nxt;
                err_cnt  <= err_cnt + {{ADDR_WIDTH{1'b0}}, err};
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        k            <= '0;
                        epoch_cnt    <= '0;
                        err_cnt      <= '0;
                        resp_cnt     <= '0;
                        converged    <= 1'b0;
                        protocol_err <= 1'b0;
                    end
                end
                ST_ISSUE_B: begin
                    if (s_ready && k != LAST_K) k <= k + ADDR_WIDTH'(1);
                end
                ST_EPOCH_END: begin
                    if (epoch_cnt != EPOCH_SAT) epoch_cnt <= epoch_cnt + EPOCH_WIDTH'(1);
                    last_err_cnt <= err_cnt;
                    if (err_cnt == '0) begin
                        converged <= 1'b1;
                    end else if (!epoch_last) begin
                        k        <= '0;
                        err_cnt  <= '0;
                        resp_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_train_sample_sequencer.sv
// Randomized bench for train_sample_sequencer against an epoch-level reference model.
module tb_train_sample_sequencer;

    localparam int NUM  = 64;
    localparam int HALF = 32;
    localparam int MAXE = 3;

    logic              clk = 1'b0;
    logic              rst_n, start;
    logic [5:0]        mem_addr_a, mem_addr_b, s_index;
    logic [17:0]       mem_data_a, mem_data_b;
    logic              s_valid, s_ready, s_label;
    logic signed [7:0] s_x1, s_x2;
    logic              err_valid, err;
    logic              busy, done, converged, protocol_err;
    logic [7:0]        epoch_cnt;
    logic [6:0]        last_err_cnt;

    always #5 clk = ~clk;

    train_sample_sequencer #(
        .SAMPLE_WIDTH(18), .ADDR_WIDTH(6), .FEAT_WIDTH(8),
        .MAX_EPOCHS(MAXE), .EPOCH_WIDTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b),
        .mem_data_a(mem_data_a), .mem_data_b(mem_data_b),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_x1(s_x1), .s_x2(s_x2), .s_label(s_label), .s_index(s_index),
        .err_valid(err_valid), .err(err),
        .busy(busy), .done(done), .converged(converged),
        .epoch_cnt(epoch_cnt), .last_err_cnt(last_err_cnt),
        .protocol_err(protocol_err)
    );

    logic [17:0] mem [NUM];
    always @(posedge clk) begin
        mem_data_a <= mem[mem_addr_a];
        mem_data_b <= mem[mem_addr_b];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // n-th sample of an epoch alternates lower half k and upper half HALF+k
    function automatic int exp_index(input int n);
        return (n % 2 == 0) ? n / 2 : HALF + n / 2;
    endfunction

    function automatic bit err_of(input int mode, input int idx, input int ep);
        case (mode)
            1:       return 1'b1;
            2:       return (idx == 5 && ep == 0);
            default: return 1'b0;
        endcase
    endfunction

    // configuration written by the main sequence only
    int ready_pct = 100, resp_dly = 1, err_mode = 0, hs_base = 0;
    int inject_req = 0, flush_req = 0;
    // state owned by the negedge driver/monitor
    int cyc = 0, hs_count = 0, resp_sent = 0, inject_ack = 0, flush_ack = 0;
    int due_q[$];
    bit err_q[$];
    bit stalled = 1'b0;
    logic [7:0] hx1, hx2;
    logic [5:0] hidx;
    logic       hlab;
    int d_n, d_ix, d_ep;

    always @(negedge clk) begin
        cyc++;
        if (flush_req != flush_ack) begin
            due_q.delete();
            err_q.delete();
            flush_ack = flush_req;
        end
        err_valid = 1'b0;
        err       = 1'b0;
        if (inject_req != inject_ack) begin
            err_valid  = 1'b1;
            inject_ack = inject_req;
        end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
            err_valid = 1'b1;
            err       = err_q.pop_front();
            void'(due_q.pop_front());
            resp_sent++;
        end
        if (stalled) begin
            check_eq("stall_valid", s_valid, 1);
            check_eq("stall_index", s_index, hidx);
            check_eq("stall_x1", {24'b0, s_x1}, hx1);
            check_eq("stall_x2", {24'b0, s_x2}, hx2);
            check_eq("stall_label", s_label, hlab);
        end
        s_ready = ($urandom_range(0, 99) < ready_pct);
        if (s_valid && s_ready) begin
            d_n  = hs_count - hs_base;
            d_ix = exp_index(d_n % NUM);
            d_ep = d_n / NUM;
            check_eq("order", s_index, d_ix);
            check_eq("x1", {24'b0, s_x1}, mem[d_ix][17:10]);
            check_eq("x2", {24'b0, s_x2}, mem[d_ix][9:2]);
            check_eq("label", s_label, mem[d_ix][1]);
            if (d_ix == 0) begin
                check_eq("idx0_x1", {24'b0, s_x1}, 32'hF0);
                check_eq("idx0_x2", {24'b0, s_x2}, 32'hF0);
                check_eq("idx0_label", s_label, 0);
            end
            if (d_ix == 33) begin
                check_eq("idx33_x1", {24'b0, s_x1}, 32'h11);
                check_eq("idx33_x2", {24'b0, s_x2}, 32'h0F);
                check_eq("idx33_label", s_label, 1);
            end
            hs_count++;
            due_q.push_back(cyc + resp_dly);
            err_q.push_back(err_of(err_mode, d_ix, d_ep));
        end
        stalled = s_valid && !s_ready;
        hidx = s_index;
        hx1  = s_x1;
        hx2  = s_x2;
        hlab = s_label;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_case(input string name, input int rp, input int dly, input int mode,
                            input bit poke);
        int  ep_exp, le_exp, e0_err, s, waited;
        bit  conv_exp, poked, seen;
        conv_exp = 1'b0; ep_exp = 0; le_exp = 0; e0_err = 0;
        for (int e = 0; e < MAXE; e++) begin
            s = 0;
            for (int i = 0; i < NUM; i++) s += int'(err_of(mode, i, e));
            if (e == 0) e0_err = s;
            ep_exp = e + 1;
            le_exp = s;
            if (s == 0) begin
                conv_exp = 1'b1;
                break;
            end
        end

        ready_pct = rp; resp_dly = dly; err_mode = mode; hs_base = hs_count;
        begin
            int resp_base;
            resp_base = resp_sent;
            pulse_start();
            check_eq($sformatf("%s.prot_clear", name), protocol_err, 0);
            check_eq($sformatf("%s.busy", name), busy, 1);
            check_eq($sformatf("%s.valid_c1", name), s_valid, 0);
            @(posedge clk); #1;
            check_eq($sformatf("%s.valid_c2", name), s_valid, 0);
            @(posedge clk); #1;
            check_eq($sformatf("%s.valid_c3", name), s_valid, 1);
            waited = 0; poked = 1'b0; seen = 1'b0;
            while (!done && waited < 20000) begin
                if (poke && !poked && epoch_cnt == 8'd1 && s_valid) begin
                    pulse_start();
                    waited++;
                    poked = 1'b1;
                    check_eq($sformatf("%s.start_busy_epoch", name), epoch_cnt, 1);
                    check_eq($sformatf("%s.start_busy_busy", name), busy, 1);
                end
                if (ep_exp > 1 && !seen && epoch_cnt == 8'd1) begin
                    seen = 1'b1;
                    check_eq($sformatf("%s.ep1_last_err", name), last_err_cnt, e0_err);
                    check_eq($sformatf("%s.ep1_responses", name), resp_sent - resp_base, NUM);
                end
                @(posedge clk); #1;
                waited++;
            end
        end
        check_eq($sformatf("%s.done", name), done, 1);
        check_eq($sformatf("%s.busy_end", name), busy, 0);
        check_eq($sformatf("%s.converged", name), converged, conv_exp);
        check_eq($sformatf("%s.epoch_cnt", name), epoch_cnt, ep_exp);
        check_eq($sformatf("%s.last_err_cnt", name), last_err_cnt, le_exp);
        check_eq($sformatf("%s.handshakes", name), hs_count - hs_base, ep_exp * NUM);
        check_eq($sformatf("%s.prot_end", name), protocol_err, 0);
        check_eq($sformatf("%s.valid_end", name), s_valid, 0);
    endtask

    initial begin
        int waited;
        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < NUM; i++) mem[i] = 18'($urandom);
        mem[0]  = {8'hF0, 8'hF0, 1'b0, 1'b0};
        mem[33] = {8'h11, 8'h0F, 1'b1, 1'b0};
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.valid", s_valid, 0);
        check_eq("rst.busy", busy, 0);
        check_eq("rst.done", done, 0);
        check_eq("rst.converged", converged, 0);
        check_eq("rst.epoch_cnt", epoch_cnt, 0);
        check_eq("rst.last_err", last_err_cnt, 0);
        check_eq("rst.prot", protocol_err, 0);
        check_eq("rst.addr_a", mem_addr_a, 0);
        check_eq("rst.addr_b", mem_addr_b, HALF);
        check_eq("rst.index", s_index, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_case("base", 100, 1, 0, 1'b0);

        inject_req++;
        repeat (2) @(posedge clk);
        #1;
        check_eq("idle_resp.prot", protocol_err, 1);
        repeat (4) @(posedge clk);
        #1;
        check_eq("idle_resp.sticky", protocol_err, 1);
        check_eq("idle_resp.done_kept", done, 1);

        run_case("noconv", 100, 1, 1, 1'b1);
        run_case("bp", 30, 1, 0, 1'b0);
        run_case("bp_err", 30, 3, 2, 1'b0);
        run_case("delay", 100, 10, 2, 1'b0);

        ready_pct = 100; resp_dly = 1; err_mode = 0; hs_base = hs_count;
        pulse_start();
        waited = 0;
        while (!(s_valid && s_index == 6'd42) && waited < 2000) begin
            @(posedge clk); #1;
            waited++;
        end
        check_eq("midrst.reach_k10", s_index, 42);
        rst_n = 1'b0;
        flush_req++;
        #1;
        check_eq("midrst.valid", s_valid, 0);
        check_eq("midrst.busy", busy, 0);
        check_eq("midrst.done", done, 0);
        check_eq("midrst.index", s_index, 0);
        check_eq("midrst.addr_a", mem_addr_a, 0);
        check_eq("midrst.addr_b", mem_addr_b, HALF);
        check_eq("midrst.epoch", epoch_cnt, 0);
        check_eq("midrst.last_err", last_err_cnt, 0);
        check_eq("midrst.x1", {24'b0, s_x1}, 0);
        check_eq("midrst.label", s_label, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_case("after_rst", 100, 1, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
